// File: rtl/mixcol_gf_scheduler.sv
// AES MixColumns / InvMixColumns over a 128-bit state, time-shared on
// GF_LANES GF(2^8) multipliers (poly 0x11B), one product term per lane per cycle.
// Ports:
//   clk, rst_n (sync, active-low)
//   in_valid / in_ready / in_data[127:0] / in_inv : input handshake, mode 1 = inverse
//   out_valid / out_ready / out_data[127:0]        : output handshake
//   busy : high while a state is in flight (RUN or DONE)

module gf_multiplier (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);
   logic [7:0] aa;

   always_comb begin
      aa = a;
      p  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
   end
endmodule

module mixcol_gf_scheduler #(
   parameter int GF_LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   generate
      if (!(GF_LANES == 1 || GF_LANES == 2 || GF_LANES == 4)) begin : g_bad_lanes
         $error("mixcol_gf_scheduler: GF_LANES must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] STEP   = 6'(GF_LANES);
   localparam logic [1:0] LAST_K = 2'(4 - GF_LANES);

   state_t       state;
   state_t       state_nx;
   logic [127:0] s_reg;
   logic         inv;
   logic [5:0]   cnt;
   logic [7:0]   acc;
   logic [1:0]   col;
   logic [1:0]   row;
   logic         last_k;
   logic [6:0]   wr_base;
   logic [7:0]   lane_p [GF_LANES];
   logic [7:0]   lane_x;

   function automatic logic [7:0] coeff(input logic inv_i, input logic [1:0] idx);
      logic [7:0] m;
      m = 8'h00;
      case ({inv_i, idx})
         3'b000: m = 8'h02;
         3'b001: m = 8'h03;
         3'b010: m = 8'h01;
         3'b011: m = 8'h01;
         3'b100: m = 8'h0e;
         3'b101: m = 8'h0b;
         3'b110: m = 8'h0d;
         3'b111: m = 8'h09;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   assign col    = cnt[5:4];
   assign row    = cnt[3:2];
   assign last_k = (cnt[1:0] == LAST_K);
   // byte n lives at bit 8*(15-n); ~n equals 15-n for a 4-bit index
   assign wr_base = {~{col, row}, 3'b000};

   genvar g;
   generate
      for (g = 0; g < GF_LANES; g++) begin : g_lane
         logic [1:0] k;
         logic [6:0] rd_base;
         logic [7:0] m;
         logic [7:0] sb;

         assign k       = cnt[1:0] + 2'(g);
         assign rd_base = {~{col, k}, 3'b000};
         assign m       = coeff(inv, k - row);
         assign sb      = s_reg[rd_base +: 8];

         gf_multiplier u_mul (
            .a (m),
            .b (sb),
            .p (lane_p[g])
         );
      end
   endgenerate

   always_comb begin
      lane_x = 8'h00;
      for (int i = 0; i < GF_LANES; i++) lane_x = lane_x ^ lane_p[i];
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last_k && cnt[5:2] == 4'hf) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_reg    <= '0;
         inv      <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s_reg <= in_data;
                  inv   <= in_inv;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + STEP;
               if (last_k) begin
                  // byte complete: fold in this cycle's lanes directly
                  out_data[wr_base +: 8] <= acc ^ lane_x;
                  acc                    <= '0;
               end else begin
                  acc <= acc ^ lane_x;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
